dma_copy_engine: RTL
====================

# dma_copy_engine

- Single-channel memory-to-memory copy engine that drives the `dma` master port of the CPU-priority RAM arbiter.
- On a start command it copies `len` XLEN-bit words from `src_addr` to `dst_addr`, one read then one write per word.
- It never has more than one read outstanding.
- It tolerates arbitrarily long stalls while the CPU holds the RAM.

## Interface
Parameters:
- XLEN, 64, data and address width; word stride is XLEN/8 bytes
- LENW, 16, width of the word-count field

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous and active-low
- start  in  1  single-cycle command pulse, honoured only in IDLE
- src_addr  in  XLEN  byte address of the first source word, sampled on accepted start
- dst_addr  in  XLEN  byte address of the first destination word, sampled on accepted start
- len  in  LENW  number of words to copy, sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until the cycle `done` pulses, inclusive
- done  out  1  one-cycle pulse when the command completes
- words_left  out  LENW  remaining word count, for status reads
- mem  Membus.master  copy traffic (`valid`, `ready`, `addr`, `wen`, `wdata`, `wmask`, `rvalid`, `rdata`)

## Operation
FSM states are IDLE, RD_REQ, RD_WAIT, WR_REQ and FINISH.
- **IDLE:** `start` latches `src_addr`, `dst_addr` and `len` into `rd_ptr`, `wr_ptr` and `remain`.
  - If `len`==0, go to FINISH.
  - Otherwise go to RD_REQ.
- **RD_REQ:** drive `mem.valid`=1, `wen`=0, `addr`=`rd_ptr`. On `valid&&ready`, go to RD_WAIT.
- **RD_WAIT:** `mem.valid`=0. On `mem.rvalid`, capture `rdata` into the `data` register and go to WR_REQ.
- **WR_REQ:** drive `mem.valid`=1, `wen`=1, `addr`=`wr_ptr`, `wdata`=`data`, `wmask`=all ones. A write completes on `ready`. On fire:
  - `rd_ptr` += XLEN/8
  - `wr_ptr` += XLEN/8
  - `remain` -= 1
  - go to FINISH if `remain`==1, otherwise to RD_REQ
- **FINISH:** `done`=1 for exactly one cycle, then go to IDLE.

Rules:
- `start` outside IDLE is ignored, with no queuing.
- Address arithmetic is modulo 2^XLEN; a pointer at 2^XLEN−8 wraps to 0.
- Request fields (`addr`, `wen`, `wdata`, `wmask`) are held stable while `valid`=1 and `ready`=0. `valid` never drops before fire.
- `mem.rvalid` outside RD_WAIT is ignored.
- `words_left` = `remain`.

## Timing
- All outputs are decoded from registered state. No combinational path from `mem.ready` or `mem.rvalid` to any output.
- Reset values:
  - state = IDLE
  - `busy`=0, `done`=0
  - `mem.valid`=0, `mem.wen`=0, `mem.addr`=0, `mem.wdata`=0, `mem.wmask`=0
  - `words_left`=0
- Reset asserted mid-transfer returns to IDLE on the next edge. Any in-flight read response is dropped, and `done` is not pulsed.
- `busy`=1 in RD_REQ, RD_WAIT, WR_REQ and FINISH.
- Best case (`ready` always 1, `rvalid` one cycle after read fire) is 3 cycles per word:
  - RD_REQ fire
  - RD_WAIT with `rvalid`
  - WR_REQ fire
- `len`=N ⇒ `done` at cycle 3N+1 after start. `len`=0 ⇒ `done` at cycle 1.
- Back-pressure adds one cycle per stall cycle. `rvalid` latency adds cycles in RD_WAIT.

## Structure
- Add to the `eei` package:
  - `dma_state_t` enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH)
  - `localparam` `WORD_BYTES` = XLEN/8
- No sub-module. Address increment and counters are inline.

## Test plan
- **Single word:** `src`=0x100, `dst`=0x200, `len`=1, ready=1, rdata=0xDEADBEEF.
  - Expect read@0x100, then write@0x200 with wdata 0xDEADBEEF and wmask all ones.
  - `done` at cycle 4.
- **Four words, contiguous:** `src`=0x1000, `dst`=0x2000.
  - Reads at 0x1000, 0x1008, 0x1010, 0x1018, each followed by the matching write.
  - `words_left` steps 4,3,2,1. `done` at cycle 13.
- **Zero length:** `len`=0.
  - No `mem.valid` ever asserted. `done` at cycle 1. `busy` high for one cycle only.
- **Arbiter stall:** hold `ready`=0 for 5 cycles in RD_REQ and 3 cycles in WR_REQ.
  - `addr`/`wen`/`wdata` stay stable throughout.
  - Completion is delayed by exactly 8 cycles.
- **Wrap and ignored start:** `src`=0xFFFF_FFFF_FFFF_FFF8, `len`=2.
  - Second read is at 0x0.
  - A `start` pulsed mid-transfer with different args changes nothing.
- **Reset mid-operation:** assert `rst`=0 while in RD_WAIT.
  - Next cycle: IDLE, `busy`=0, `mem.valid`=0, no `done`.
  - A late `rvalid` has no effect.
  - A fresh `start` then completes normally.

Source files
------------

// File: rtl/eei_pkg.sv
// Shared definitions for the execution-environment blocks.
// Holds the DMA copy engine state encoding and word geometry.
package eei;

  localparam int XLEN_BITS  = 64;
  localparam int WORD_BYTES = XLEN_BITS / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } dma_state_t;

endpackage

// File: rtl/membus.sv
// Simple valid/ready memory bus with a separate read-response strobe.
// Masters hold request fields steady until the request fires.
interface Membus #(
  parameter int XLEN = 64
);

  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   addr;
  logic              wen;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wmask;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output valid,
    output addr,
    output wen,
    output wdata,
    output wmask,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  valid,
    input  addr,
    input  wen,
    input  wdata,
    input  wmask,
    output ready,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/dma_copy_engine.sv
// Single-channel word copy engine: one read, then one write, per word.
// Every output is a flop, so bus handshakes never reach outputs directly.
module dma_copy_engine #(
  parameter int XLEN = 64,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] src_addr,
  input  logic [XLEN-1:0] dst_addr,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic [LENW-1:0] words_left,
  Membus.master           mem
);

  import eei::*;

  localparam logic [XLEN-1:0] STEP = XLEN'(XLEN / 8);
  localparam logic [LENW-1:0] ONE  = LENW'(1);

  dma_state_t        state_q;
  logic [XLEN-1:0]   rd_ptr_q;
  logic [XLEN-1:0]   wr_ptr_q;
  logic [XLEN-1:0]   rd_ptr_d;
  logic [XLEN-1:0]   wr_ptr_d;
  logic [LENW-1:0]   remain_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic              wen_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN/8-1:0] wmask_q;
  logic              fire;

  assign fire     = valid_q & mem.ready;
  assign rd_ptr_d = rd_ptr_q + STEP;
  assign wr_ptr_d = wr_ptr_q + STEP;

  // Request fields are only rewritten on entry to a request state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rd_ptr_q <= src_addr;
            wr_ptr_q <= dst_addr;
            remain_q <= len;
            busy_q   <= 1'b1;
            if (len == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_REQ;
              valid_q <= 1'b1;
              wen_q   <= 1'b0;
              addr_q  <= src_addr;
            end
          end
        end
        RD_REQ: begin
          if (fire) begin
            state_q <= RD_WAIT;
            valid_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem.rvalid) begin
            state_q <= WR_REQ;
            valid_q <= 1'b1;
            wen_q   <= 1'b1;
            addr_q  <= wr_ptr_q;
            wdata_q <= mem.rdata;
            wmask_q <= '1;
          end
        end
        WR_REQ: begin
          if (fire) begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            remain_q <= remain_q - ONE;
            wen_q    <= 1'b0;
            wmask_q  <= '0;
            if (remain_q == ONE) begin
              state_q <= FINISH;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_REQ;
              addr_q  <= rd_ptr_d;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_left = remain_q;
  assign mem.valid  = valid_q;
  assign mem.wen    = wen_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign mem.wmask  = wmask_q;

endmodule
